// File: rtl/node_mem_pkg.sv
// Shared types and default geometry for the node/data memory controller.
package node_mem_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_ADDR_W   = 11;
   localparam int DEF_NODE_CNT = 16;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_BURST = 2'd2
   } nodeState_t;

   // Node vector at the default geometry: slot i holds word base+i.
   typedef logic [DEF_NODE_CNT-1:0][DEF_DATA_W-1:0] nodeVec_t;

endpackage

// File: rtl/node_data_mem_if.sv
// Bus bundle between the processor/NN datapath (master) and the memory controller (slave).
interface node_data_mem_if
   import node_mem_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NODE_CNT = DEF_NODE_CNT
);
   // Requests are single-cycle strobes sampled at the clock edge and only honoured
   // while oReady=1; a data read answers with oDataValid exactly one cycle later,
   // a node burst answers with a one-cycle oNodesValid pulse when oNodes is complete.
   logic                             iDataReq;
   logic                             iDataWrite;
   logic [ADDR_W-1:0]                iDataAddr;
   logic [DATA_W-1:0]                iData;
   logic [DATA_W-1:0]                oData;
   logic                             oDataValid;
   logic                             iNodeReq;
   logic [ADDR_W-1:0]                iNodeAddr;
   logic                             oNodeBusy;
   logic [NODE_CNT-1:0][DATA_W-1:0]  oNodes;
   logic                             oNodesValid;
   logic                             oReady;

   modport master (
      output iDataReq, iDataWrite, iDataAddr, iData, iNodeReq, iNodeAddr,
      input  oData, oDataValid, oNodeBusy, oNodes, oNodesValid, oReady
   );

   modport slave (
      input  iDataReq, iDataWrite, iDataAddr, iData, iNodeReq, iNodeAddr,
      output oData, oDataValid, oNodeBusy, oNodes, oNodesValid, oReady
   );

endinterface

// File: rtl/node_mem_ram.sv
// Single-port synchronous RAM with registered read data; no reset so it maps onto block RAM.
module node_mem_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11
) (
   input  logic              iclk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge iclk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/node_data_mem.sv
// Data/node memory controller: one RAM port shared by a word data port and a node burst engine.
// Define NODE_MEM_CLEAR_EN to zero the whole RAM after reset before oReady rises.
module node_data_mem
   import node_mem_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NODE_CNT = DEF_NODE_CNT
) (
   input  logic           iclk,
   input  logic           irst,
   node_data_mem_if.slave bus,
   output nodeState_t     oState
);

   localparam int IDX_W = $clog2(NODE_CNT);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NODE_CNT - 1);
   localparam logic [IDX_W:0]   ISSUE_END = (IDX_W+1)'(NODE_CNT);

   nodeState_t                      state;
   logic [ADDR_W-1:0]               baseAddr;
   logic [IDX_W:0]                  issueCnt;
   logic [IDX_W-1:0]                capIdx;
   logic                            capPend;
   logic                            ready;
   logic                            dataValid;
   logic [DATA_W-1:0]               dataHold;
   logic                            nodeBusy;
   logic                            nodesValid;
   logic [NODE_CNT-1:0][DATA_W-1:0] nodes;

   logic                            ramWe;
   logic [ADDR_W-1:0]               ramAddr;
   logic [DATA_W-1:0]               ramWdata;
   logic [DATA_W-1:0]               ramRdata;
   logic                            dataAcc;
   logic                            issuing;
`ifdef NODE_MEM_CLEAR_EN
   logic [ADDR_W-1:0]               clrCnt;
`endif

   // The data port owns the RAM whenever it asks; the burst issues only in leftover cycles.
   assign dataAcc = ready & bus.iDataReq;
   assign issuing = (state == ST_BURST) && !dataAcc && (issueCnt != ISSUE_END);

   always_comb begin
      ramWe    = 1'b0;
      ramAddr  = baseAddr + ADDR_W'(issueCnt[IDX_W-1:0]);
      ramWdata = bus.iData;
`ifdef NODE_MEM_CLEAR_EN
      if (state == ST_CLEAR) begin
         ramWe    = 1'b1;
         ramAddr  = clrCnt;
         ramWdata = '0;
      end else
`endif
      if (dataAcc) begin
         ramWe   = bus.iDataWrite;
         ramAddr = bus.iDataAddr;
      end
   end

   node_mem_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) uRam (
      .iclk  (iclk),
      .we    (ramWe),
      .addr  (ramAddr),
      .wdata (ramWdata),
      .rdata (ramRdata)
   );

   always_ff @(posedge iclk) begin
      if (irst) begin
`ifdef NODE_MEM_CLEAR_EN
         state  <= ST_CLEAR;
         clrCnt <= '0;
`else
         state  <= ST_IDLE;
`endif
         ready      <= 1'b0;
         dataValid  <= 1'b0;
         dataHold   <= '0;
         nodes      <= '0;
         nodeBusy   <= 1'b0;
         nodesValid <= 1'b0;
         baseAddr   <= '0;
         issueCnt   <= '0;
         capIdx     <= '0;
         capPend    <= 1'b0;
      end else begin
         dataValid  <= dataAcc & ~bus.iDataWrite;
         nodesValid <= 1'b0;
         // RAM read data moves on with every burst issue, so keep the last answer.
         if (dataValid) dataHold <= ramRdata;
         case (state)
`ifdef NODE_MEM_CLEAR_EN
            ST_CLEAR: begin
               clrCnt <= clrCnt + 1'b1;
               if (&clrCnt) begin
                  state <= ST_IDLE;
                  ready <= 1'b1;
               end
            end
`endif
            ST_IDLE: begin
               ready <= 1'b1;
               if (bus.iNodeReq && ready && !nodesValid) begin
                  baseAddr <= bus.iNodeAddr;
                  issueCnt <= '0;
                  capIdx   <= '0;
                  capPend  <= 1'b0;
                  nodeBusy <= 1'b1;
                  state    <= ST_BURST;
               end
            end
            ST_BURST: begin
               capPend <= issuing;
               if (issuing) issueCnt <= issueCnt + 1'b1;
               if (capPend) begin
                  nodes[capIdx] <= ramRdata;
                  capIdx        <= capIdx + 1'b1;
                  if (capIdx == LAST_IDX) begin
                     nodesValid <= 1'b1;
                     nodeBusy   <= 1'b0;
                     state      <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.oData       = dataValid ? ramRdata : dataHold;
   assign bus.oDataValid  = dataValid;
   assign bus.oNodeBusy   = nodeBusy;
   assign bus.oNodes      = nodes;
   assign bus.oNodesValid = nodesValid;
   assign bus.oReady      = ready;
   assign oState          = state;

endmodule

// File: tb/tb_node_data_mem.sv
// Bench for node_data_mem: vector table for the data port, hand sequences and random bursts vs a word-array model.
module tb_node_data_mem;
   import node_mem_pkg::*;

   localparam int DATA_W   = DEF_DATA_W;
   localparam int ADDR_W   = DEF_ADDR_W;
   localparam int NODE_CNT = DEF_NODE_CNT;
   localparam int DEPTH    = 1 << ADDR_W;
`ifdef NODE_MEM_CLEAR_EN
   localparam int READY_LAT = DEPTH;
`else
   localparam int READY_LAT = 1;
`endif

   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] expData;
   } dataVec_t;

   logic       iclk;
   logic       irst;
   nodeState_t dbgState;

   node_data_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NODE_CNT(NODE_CNT)) bus ();

   node_data_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NODE_CNT(NODE_CNT)) dut (
      .iclk   (iclk),
      .irst   (irst),
      .bus    (bus),
      .oState (dbgState)
   );

   // clock / watchdog
   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard
   int                vecCnt  = 0;
   int                missCnt = 0;
   logic [DATA_W-1:0] expQ[$];
   logic [DATA_W-1:0] model [DEPTH];
   logic [DATA_W-1:0] lastRead = '0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecCnt++;
      if (act !== exp) begin
         missCnt++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic scoreRead(input string nm);
      check({nm, "Valid"}, {31'd0, bus.oDataValid}, 32'd1);
      if (expQ.size() != 0) begin
         lastRead = expQ.pop_front();
         check(nm, {16'd0, bus.oData}, {16'd0, lastRead});
      end
   endtask

   // driver tasks
   task automatic doWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.iDataReq = 1'b1; bus.iDataWrite = 1'b1; bus.iDataAddr = a; bus.iData = d;
      @(negedge iclk);
      bus.iDataReq = 1'b0; bus.iDataWrite = 1'b0;
      model[a] = d;
      check("wrNoValid", {31'd0, bus.oDataValid}, 32'd0);
      check("wrHold", {16'd0, bus.oData}, {16'd0, lastRead});
   endtask

   task automatic doRead(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
      bus.iDataReq = 1'b1; bus.iDataWrite = 1'b0; bus.iDataAddr = a;
      expQ.push_back(e);
      @(negedge iclk);
      bus.iDataReq = 1'b0;
      scoreRead("rdData");
   endtask

   task automatic waitReady(input int start, output int n, output int stray);
      n = start; stray = 0;
      while (!bus.oReady && n < 4 * DEPTH) begin
         @(negedge iclk);
         n++;
         if (bus.oNodesValid || bus.oDataValid) stray++;
      end
   endtask

   // Burst with optional data accesses: stallMask bit c puts a data access on edge c+1 after
   // acceptance (a write where wrMask is also set). Expected nodes are snapshots of the model
   // taken on each edge that is free for the burst to read its next word.
   task automatic runBurst(input logic [ADDR_W-1:0] base, input logic [31:0] stallMask,
                           input logic [31:0] wrMask, input int expLat, input logic tryB2b);
      logic [DATA_W-1:0] expNodes [NODE_CNT];
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      int issued, lat, c;
      logic busyOk, isRd;
      bus.iNodeAddr = base; bus.iNodeReq = 1'b1;
      @(negedge iclk);
      bus.iNodeReq = 1'b0;
      check("acceptBusy", {31'd0, bus.oNodeBusy}, 32'd1);
      issued = 0; lat = -1; c = 0; busyOk = 1'b1;
      while (lat < 0 && c < 200) begin
         isRd = 1'b0;
         if (c < 32 && stallMask[c]) begin
            a = base + ADDR_W'($urandom_range(0, NODE_CNT - 1));
            bus.iDataReq = 1'b1; bus.iDataAddr = a;
            if (wrMask[c]) begin
               d = DATA_W'($urandom);
               bus.iDataWrite = 1'b1; bus.iData = d;
               model[a] = d;
            end else begin
               bus.iDataWrite = 1'b0;
               expQ.push_back(model[a]);
               isRd = 1'b1;
            end
         end else if (issued < NODE_CNT) begin
            expNodes[issued] = model[base + ADDR_W'(issued)];
            issued++;
         end
         @(negedge iclk);
         c++;
         bus.iDataReq = 1'b0; bus.iDataWrite = 1'b0;
         if (isRd) scoreRead("burstRd");
         if (bus.oNodesValid) lat = c;
         else if (!bus.oNodeBusy) busyOk = 1'b0;
      end
      check("busyHeld", {31'd0, busyOk}, 32'd1);
      check("nodeLatency", lat, expLat);
      for (int i = 0; i < NODE_CNT; i++)
         check($sformatf("node%0d", i), {16'd0, bus.oNodes[i]}, {16'd0, expNodes[i]});
      bus.iNodeReq = tryB2b;
      @(negedge iclk);
      check("pulseOnce", {31'd0, bus.oNodesValid}, 32'd0);
      check("busyDone", {31'd0, bus.oNodeBusy}, 32'd0);
      check("dataHeld", {16'd0, bus.oData}, {16'd0, lastRead});
   endtask

   // stimulus
   dataVec_t vecs [8];

   initial begin
      int n, stray, lat;
      logic [31:0] sm, wm;
      logic [ADDR_W-1:0] b;

      vecs[0] = '{1'b1, 11'h005, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b0, 11'h005, 16'h0000, 16'hBEEF};
      vecs[2] = '{1'b1, 11'h7FF, 16'h1234, 16'h0000};
      vecs[3] = '{1'b0, 11'h7FF, 16'h0000, 16'h1234};
      vecs[4] = '{1'b1, 11'h000, 16'hFFFF, 16'h0000};
      vecs[5] = '{1'b0, 11'h000, 16'h0000, 16'hFFFF};
      vecs[6] = '{1'b1, 11'h005, 16'h0001, 16'h0000};
      vecs[7] = '{1'b0, 11'h005, 16'h0000, 16'h0001};

      bus.iDataReq = 1'b0; bus.iDataWrite = 1'b0; bus.iDataAddr = '0; bus.iData = '0;
      bus.iNodeReq = 1'b0; bus.iNodeAddr = '0;
      irst = 1'b1;
      repeat (2) @(negedge iclk);
      check("rstData", {16'd0, bus.oData}, 32'd0);
      check("rstDataValid", {31'd0, bus.oDataValid}, 32'd0);
      check("rstNodesZero", {31'd0, (bus.oNodes == '0)}, 32'd1);
      check("rstBusy", {31'd0, bus.oNodeBusy}, 32'd0);
      check("rstNodesValid", {31'd0, bus.oNodesValid}, 32'd0);
      check("rstReady", {31'd0, bus.oReady}, 32'd0);

      // read on the first cycle after release is ignored
      irst = 1'b0;
      bus.iDataReq = 1'b1; bus.iDataWrite = 1'b0; bus.iDataAddr = 11'h123;
      @(negedge iclk);
      bus.iDataReq = 1'b0;
      check("cycle1NoValid", {31'd0, bus.oDataValid}, 32'd0);
      waitReady(1, n, stray);
      check("readyLatency", n, READY_LAT);
      check("readyStray", stray, 0);
`ifdef NODE_MEM_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      doRead(11'h123, 16'h0000);
`endif

      // data port vector table
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].wr) doWrite(vecs[i].addr, vecs[i].wdata);
         else            doRead(vecs[i].addr, vecs[i].expData);
      end
      @(negedge iclk);
      check("idleNoValid", {31'd0, bus.oDataValid}, 32'd0);
      check("idleHold", {16'd0, bus.oData}, 32'h0001);

      // plain burst, stalled burst, back-to-back request in the pulse cycle
      for (int i = 0; i < NODE_CNT; i++) doWrite(11'h100 + ADDR_W'(i), 16'h1000 + DATA_W'(i));
      runBurst(11'h100, 32'd0, 32'd0, NODE_CNT + 1, 1'b0);
      for (int i = 0; i < NODE_CNT; i++)
         check($sformatf("base100node%0d", i), {16'd0, bus.oNodes[i]}, 32'h1000 + i);
      runBurst(11'h100, (32'd1 << 3) | (32'd1 << 6) | (32'd1 << 9), 32'd0, NODE_CNT + 4, 1'b1);
      runBurst(11'h100, 32'd0, 32'd0, NODE_CNT + 1, 1'b0);

      // address wrap
      for (int i = 0; i < 4; i++)  doWrite(11'h7FC + ADDR_W'(i), DATA_W'(i + 1));
      for (int i = 0; i < 12; i++) doWrite(ADDR_W'(i), DATA_W'(i + 5));
      runBurst(11'h7FC, 32'd0, 32'd0, NODE_CNT + 1, 1'b0);
      for (int i = 0; i < NODE_CNT; i++)
         check($sformatf("wrapNode%0d", i), {16'd0, bus.oNodes[i]}, i + 1);

      // reset in the middle of a burst
      bus.iNodeAddr = 11'h200; bus.iNodeReq = 1'b1;
      @(negedge iclk);
      bus.iNodeReq = 1'b0;
      repeat (4) @(negedge iclk);
      irst = 1'b1;
      @(negedge iclk);
      irst = 1'b0;
      check("abortNodesValid", {31'd0, bus.oNodesValid}, 32'd0);
      check("abortBusy", {31'd0, bus.oNodeBusy}, 32'd0);
      check("abortNodesZero", {31'd0, (bus.oNodes == '0)}, 32'd1);
      check("abortReady", {31'd0, bus.oReady}, 32'd0);
      lastRead = '0;
      waitReady(0, n, stray);
      check("abortReadyLatency", n, READY_LAT);
      check("abortStray", stray, 0);
`ifdef NODE_MEM_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
      for (int i = 0; i < NODE_CNT; i++) doWrite(11'h200 + ADDR_W'(i), DATA_W'($urandom));
      runBurst(11'h200, 32'd0, 32'd0, NODE_CNT + 1, 1'b0);

      // random traffic in a 64-word window
      for (int i = 0; i < 64; i++) doWrite(11'h300 + ADDR_W'(i), DATA_W'($urandom));
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 2))
            0: doWrite(11'h300 + ADDR_W'($urandom_range(0, 63)), DATA_W'($urandom));
            1: begin
               b = 11'h300 + ADDR_W'($urandom_range(0, 63));
               doRead(b, model[b]);
            end
            default: begin
               b  = 11'h300 + ADDR_W'($urandom_range(0, 48));
               sm = $urandom & $urandom & 32'h0000_FFFF;
               wm = sm & $urandom;
               lat = NODE_CNT + 1 + $countones(sm);
               runBurst(b, sm, wm, lat, 1'b0);
            end
         endcase
      end

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
      $finish;
   end

endmodule
